// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-envelope sequencer and the PWM stage.
// The PWM stage imports the same peak so both blocks agree on full brightness.
package breath_pkg;

    localparam int                    PKG_DUTY_W   = 16;
    localparam logic [PKG_DUTY_W-1:0] PKG_DUTY_MAX = 16'h0FFF;
    localparam int                    PKG_STEP_W   = 4;
    localparam int                    PKG_HOLD_W   = 8;

    // Encodings double as the phase codes seen on the phase output.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } breath_state_e;

endpackage

// File: rtl/breath_cfg_reg.sv
// Configuration holding register: one pending slot behind a valid/ready handshake,
// copied into the active set only when the sequencer signals an envelope boundary.
module breath_cfg_reg #(
    parameter int STEP_W = 4,
    parameter int HOLD_W = 8
) (
    input  logic              duty_clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold_hi,
    input  logic [HOLD_W-1:0] cfg_hold_lo,
    input  logic              i_apply,
    output logic              cfg_ready,
    output logic [STEP_W-1:0] o_step,
    output logic [HOLD_W-1:0] o_hold_hi,
    output logic [HOLD_W-1:0] o_hold_lo
);

    logic              r_pend_valid;
    logic [STEP_W-1:0] r_pend_step;
    logic [HOLD_W-1:0] r_pend_hold_hi;
    logic [HOLD_W-1:0] r_pend_hold_lo;
    logic [STEP_W-1:0] r_act_step;
    logic [HOLD_W-1:0] r_act_hold_hi;
    logic [HOLD_W-1:0] r_act_hold_lo;
    logic              w_xfer;
    logic [STEP_W-1:0] w_step_norm;

    // Only a full slot blocks new offers, so a transfer and an apply can never
    // coincide: a config accepted on a boundary tick waits for the next boundary.
    assign cfg_ready   = ~r_pend_valid;
    assign w_xfer      = cfg_valid & ~r_pend_valid;
    assign w_step_norm = (cfg_step == '0) ? STEP_W'(1) : cfg_step;

    always_ff @(posedge duty_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid   <= 1'b0;
            r_pend_step    <= '0;
            r_pend_hold_hi <= '0;
            r_pend_hold_lo <= '0;
            r_act_step     <= STEP_W'(1);
            r_act_hold_hi  <= '0;
            r_act_hold_lo  <= '0;
        end else if (w_xfer) begin
            r_pend_valid   <= 1'b1;
            r_pend_step    <= w_step_norm;
            r_pend_hold_hi <= cfg_hold_hi;
            r_pend_hold_lo <= cfg_hold_lo;
        end else if (i_apply && r_pend_valid) begin
            r_pend_valid   <= 1'b0;
            r_act_step     <= r_pend_step;
            r_act_hold_hi  <= r_pend_hold_hi;
            r_act_hold_lo  <= r_pend_hold_lo;
        end
    end

    assign o_step    = r_act_step;
    assign o_hold_hi = r_act_hold_hi;
    assign o_hold_lo = r_act_hold_lo;

endmodule

// File: rtl/breath_env_gen.sv
// Brightness-envelope sequencer: rise / hold-high / fall / hold-low, one step per
// PWM period, with settings swapped in only between envelopes.
module breath_env_gen
    import breath_pkg::*;
#(
    parameter int                DUTY_W   = PKG_DUTY_W,
    parameter logic [DUTY_W-1:0] DUTY_MAX = PKG_DUTY_MAX,
    parameter int                STEP_W   = PKG_STEP_W,
    parameter int                HOLD_W   = PKG_HOLD_W
) (
    input  logic              duty_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold_hi,
    input  logic [HOLD_W-1:0] cfg_hold_lo,
    output logic [DUTY_W-1:0] duty,
    output logic [2:0]        phase,
    output logic              cycle_done
);

    breath_state_e     r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [HOLD_W-1:0] r_cnt;
    logic              r_cycle_done;

    logic [STEP_W-1:0] w_step;
    logic [HOLD_W-1:0] w_hold_hi;
    logic [HOLD_W-1:0] w_hold_lo;
    logic [DUTY_W-1:0] w_step_ext;
    logic [DUTY_W:0]   w_sum;
    logic              w_boundary;

    // IDLE applies a pending config whether or not en is high.
    assign w_boundary = (r_state == S_IDLE) || ((r_state == S_HOLD_LO) && (r_cnt == '0));

    breath_cfg_reg #(
        .STEP_W (STEP_W),
        .HOLD_W (HOLD_W)
    ) u_cfg (
        .duty_clk    (duty_clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_step    (cfg_step),
        .cfg_hold_hi (cfg_hold_hi),
        .cfg_hold_lo (cfg_hold_lo),
        .i_apply     (w_boundary),
        .cfg_ready   (cfg_ready),
        .o_step      (w_step),
        .o_hold_hi   (w_hold_hi),
        .o_hold_lo   (w_hold_lo)
    );

    assign w_step_ext = DUTY_W'(w_step);
    assign w_sum      = {1'b0, r_duty} + {1'b0, w_step_ext};

    always_ff @(posedge duty_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_duty       <= '0;
            r_cnt        <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_duty <= '0;
                    if (en) r_state <= S_RISE;
                end
                S_RISE: begin
                    // Sum carries one extra bit so a large step saturates instead of wrapping.
                    if (w_sum >= {1'b0, DUTY_MAX}) begin
                        r_duty  <= DUTY_MAX;
                        r_cnt   <= w_hold_hi;
                        r_state <= S_HOLD_HI;
                    end else begin
                        r_duty <= w_sum[DUTY_W-1:0];
                    end
                end
                S_HOLD_HI: begin
                    if (r_cnt == '0) r_state <= S_FALL;
                    else             r_cnt   <= r_cnt - HOLD_W'(1);
                end
                S_FALL: begin
                    if (r_duty <= w_step_ext) begin
                        r_duty  <= '0;
                        r_cnt   <= w_hold_lo;
                        r_state <= S_HOLD_LO;
                    end else begin
                        r_duty <= r_duty - w_step_ext;
                    end
                end
                S_HOLD_LO: begin
                    if (r_cnt == '0) begin
                        r_cycle_done <= 1'b1;
                        r_state      <= en ? S_RISE : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_duty  <= '0;
                end
            endcase
        end
    end

    assign duty       = r_duty;
    assign phase      = r_state;
    assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_breath_env_gen.sv
// Directed bench for breath_env_gen with a 16-count peak so envelopes stay short.
module tb_breath_env_gen;

    localparam int DUTY_W = 16;
    localparam int STEP_W = 4;
    localparam int HOLD_W = 8;

    logic              duty_clk;
    logic              rst_n;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [STEP_W-1:0] cfg_step;
    logic [HOLD_W-1:0] cfg_hold_hi;
    logic [HOLD_W-1:0] cfg_hold_lo;
    logic [DUTY_W-1:0] duty;
    logic [2:0]        phase;
    logic              cycle_done;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;

    breath_env_gen #(
        .DUTY_W   (DUTY_W),
        .DUTY_MAX (16'd16),
        .STEP_W   (STEP_W),
        .HOLD_W   (HOLD_W)
    ) dut (
        .duty_clk    (duty_clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_step    (cfg_step),
        .cfg_hold_hi (cfg_hold_hi),
        .cfg_hold_lo (cfg_hold_lo),
        .duty        (duty),
        .phase       (phase),
        .cycle_done  (cycle_done)
    );

    initial duty_clk = 1'b0;
    always #5 duty_clk = ~duty_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge duty_clk);
        #1;
        k++;
    endtask

    task automatic st(input int d, input int p, input int c);
        tick();
        chk($sformatf("duty@%0d", k), 32'(duty), d);
        chk($sformatf("phase@%0d", k), 32'(phase), p);
        chk($sformatf("done@%0d", k), 32'(cycle_done), c);
    endtask

    task automatic period_step4();
        st(4, 1, 0); st(8, 1, 0); st(12, 1, 0); st(16, 2, 0); st(16, 3, 0);
        st(12, 3, 0); st(8, 3, 0); st(4, 3, 0); st(0, 4, 0); st(0, 1, 1);
    endtask

    task automatic env_step4_h3_l2_rise();
        st(4, 1, 0); st(8, 1, 0); st(12, 1, 0);
        repeat (4) st(16, 2, 0);
        st(16, 3, 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        cfg_step = '0; cfg_hold_hi = '0; cfg_hold_lo = '0;
        #12;
        chk("rst_duty", 32'(duty), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_done", 32'(cycle_done), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        rst_n = 1'b1;
        st(0, 0, 0);

        // load step 4 while idle
        cfg_valid = 1'b1; cfg_step = 4'd4; cfg_hold_hi = 8'd0; cfg_hold_lo = 8'd0;
        tick();
        chk("load_ready_lo", 32'(cfg_ready), 0);
        chk("load_phase", 32'(phase), 0);
        cfg_valid = 1'b0;
        tick();
        chk("load_ready_hi", 32'(cfg_ready), 1);

        // basic envelope, two periods
        en = 1'b1;
        st(0, 1, 0);
        period_step4();
        period_step4();

        // step 8 offered mid-RISE
        cfg_valid = 1'b1; cfg_step = 4'd8;
        st(4, 1, 0);
        chk("mid_ready_lo", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        st(8, 1, 0); st(12, 1, 0); st(16, 2, 0); st(16, 3, 0);
        st(12, 3, 0); st(8, 3, 0); st(4, 3, 0); st(0, 4, 0);
        chk("pend_ready_lo", 32'(cfg_ready), 0);
        st(0, 1, 1);
        chk("apply_ready_hi", 32'(cfg_ready), 1);
        st(8, 1, 0); st(16, 2, 0); st(16, 3, 0); st(8, 3, 0); st(0, 4, 0);

        // step 5 offered on the boundary tick: applies one envelope later
        cfg_valid = 1'b1; cfg_step = 4'd5;
        st(0, 1, 1);
        chk("bnd_ready_lo", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        st(8, 1, 0); st(16, 2, 0); st(16, 3, 0); st(8, 3, 0); st(0, 4, 0); st(0, 1, 1);
        chk("bnd_ready_hi", 32'(cfg_ready), 1);

        // step 5 saturating envelope, with step 4 / holds 3,2 queued at its start
        cfg_valid = 1'b1; cfg_step = 4'd4; cfg_hold_hi = 8'd3; cfg_hold_lo = 8'd2;
        st(5, 1, 0);
        chk("hold_ready_lo", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        st(10, 1, 0); st(15, 1, 0); st(16, 2, 0); st(16, 3, 0);
        st(11, 3, 0); st(6, 3, 0); st(1, 3, 0); st(0, 4, 0); st(0, 1, 1);
        chk("hold_ready_hi", 32'(cfg_ready), 1);

        // hold times 3 / 2
        env_step4_h3_l2_rise();
        st(12, 3, 0); st(8, 3, 0); st(4, 3, 0);
        repeat (3) st(0, 4, 0);
        st(0, 1, 1);

        // drop en during FALL
        env_step4_h3_l2_rise();
        en = 1'b0;
        st(12, 3, 0); st(8, 3, 0); st(4, 3, 0);
        repeat (3) st(0, 4, 0);
        st(0, 0, 1);
        st(0, 0, 0); st(0, 0, 0);
        en = 1'b1;
        st(0, 1, 0); st(4, 1, 0);

        // async reset mid-HOLD_HI
        st(8, 1, 0); st(12, 1, 0); st(16, 2, 0); st(16, 2, 0);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(duty), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_ready", 32'(cfg_ready), 1);
        chk("arst_done", 32'(cycle_done), 0);
        #2;
        rst_n = 1'b1;
        st(0, 0, 0);

        // step 0 becomes step 1
        cfg_valid = 1'b1; cfg_step = 4'd0; cfg_hold_hi = 8'd0; cfg_hold_lo = 8'd0;
        tick();
        chk("s0_ready_lo", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        tick();
        chk("s0_ready_hi", 32'(cfg_ready), 1);
        en = 1'b1;
        st(0, 1, 0); st(1, 1, 0); st(2, 1, 0); st(3, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
